// File: rtl/hex_sched_pkg.sv
// Shared types and constants for the HEX display scheduler.
// Build option: HEX_ACTIVE_LOW_EN selects active-low (common-anode) segment polarity.
package hex_sched_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, OPEN} sched_state_t;

    typedef logic [7:0] seg7_t;
    typedef seg7_t [5:0] hex_image_t;

`ifdef HEX_ACTIVE_LOW_EN
    localparam seg7_t SEG_BLANK = 8'hFF;
`else
    localparam seg7_t SEG_BLANK = 8'h00;
`endif

endpackage

// File: rtl/hex_display_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_ptr and wraps,
// skipping any source set in i_exclude. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_exclude,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_winner,
    output logic          o_any
);

    logic [N-1:0] w_masked;

    assign w_masked = i_req & ~i_exclude;
    assign o_any    = |w_masked;

    // First eligible requester at or after the pointer, wrapping modulo N.
    always_comb begin
        logic found;
        int   idx;
        o_winner = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(i_ptr) + i) % N;
            if (!found && w_masked[idx]) begin
                o_winner[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// Shares HEX0..HEX5 between N_SRC display sources: round-robin ownership with a
// minimum hold time and an optional urgent source 0.
// Build option: HEX_ACTIVE_LOW_EN inverts the HEX output registers (blank = 8'hFF).
module hex_display_scheduler
    import hex_sched_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int HOLD_TICKS  = 50_000,
    parameter int URGENT_EN_P = 1
) (
    input  logic                 CLK_50,
    input  logic                 rst_i,
    input  logic [N_SRC-1:0]     req_i,
    input  logic [N_SRC*48-1:0]  seg_i,
    output logic [N_SRC-1:0]     grant_o,
    output logic                 switch_o,
    output logic [7:0]           HEX0,
    output logic [7:0]           HEX1,
    output logic [7:0]           HEX2,
    output logic [7:0]           HEX3,
    output logic [7:0]           HEX4,
    output logic [7:0]           HEX5
);

    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD_TICKS - 1);

    sched_state_t     r_state, w_state_next;
    logic [N_SRC-1:0] r_grant, w_grant_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [PW-1:0]    r_ptr, w_ptr_next;
    logic             r_switch;
    hex_image_t       r_hex, w_image;

    logic [N_SRC-1:0] w_win;
    logic             w_any;
    logic [PW-1:0]    w_win_ptr;
    logic             w_owner_req;
    logic             w_urgent;
    logic             w_sticky0;

    // Arbitration always excludes the current owner: it is either still the
    // only candidate (kept) or has dropped its request (not eligible anyway).
    rr_arbiter #(.N(N_SRC), .PW(PW)) u_arb (
        .i_req     (req_i),
        .i_exclude (r_grant),
        .i_ptr     (r_ptr),
        .o_winner  (w_win),
        .o_any     (w_any)
    );

    assign w_owner_req = |(req_i & r_grant);
    assign w_urgent    = (URGENT_EN_P != 0) && req_i[0] && !r_grant[0];
    assign w_sticky0   = (URGENT_EN_P != 0) && r_grant[0];

    // Pointer value after granting the arbiter winner: one past the winner.
    always_comb begin
        w_win_ptr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_win[i]) w_win_ptr = PW'((i + 1) % N_SRC);
        end
    end

    // Ownership decision: urgent > owner drop > hold expiry > open re-arbitration.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_cnt_next   = r_cnt;
        w_ptr_next   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_next = w_win;
                    w_ptr_next   = w_win_ptr;
                    w_cnt_next   = CNT_RELOAD;
                    w_state_next = HOLD;
                end
            end
            default: begin
                if (w_urgent) begin
                    w_grant_next = N_SRC'(1);
                    w_ptr_next   = PW'(1);
                    w_cnt_next   = CNT_RELOAD;
                    w_state_next = HOLD;
                end else if (!w_owner_req) begin
                    if (w_any) begin
                        w_grant_next = w_win;
                        w_ptr_next   = w_win_ptr;
                        w_cnt_next   = CNT_RELOAD;
                        w_state_next = HOLD;
                    end else begin
                        w_grant_next = '0;
                        w_cnt_next   = '0;
                        w_state_next = IDLE;
                    end
                end else if (r_state == HOLD) begin
                    if (r_cnt == '0) w_state_next = OPEN;
                    else             w_cnt_next   = r_cnt - 1'b1;
                end else if (w_any && !w_sticky0) begin
                    w_grant_next = w_win;
                    w_ptr_next   = w_win_ptr;
                    w_cnt_next   = CNT_RELOAD;
                    w_state_next = HOLD;
                end
            end
        endcase
    end

    // One-hot mux of the owner's image; all-zero when nobody owns the display.
    always_comb begin
        w_image = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (r_grant[k]) w_image = w_image | seg_i[k*48 +: 48];
        end
    end

    // Scheduler state registers.
    always_ff @(posedge CLK_50 or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_switch <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_cnt    <= w_cnt_next;
            r_ptr    <= w_ptr_next;
            r_switch <= (w_grant_next != r_grant);
        end
    end

    // Segment output registers, polarity applied here so blank falls out of the zero image.
    always_ff @(posedge CLK_50 or posedge rst_i) begin
        if (rst_i) begin
            r_hex <= {6{SEG_BLANK}};
        end else begin
`ifdef HEX_ACTIVE_LOW_EN
            r_hex <= ~w_image;
`else
            r_hex <= w_image;
`endif
        end
    end

    assign grant_o  = r_grant;
    assign switch_o = r_switch;
    assign HEX0     = r_hex[0];
    assign HEX1     = r_hex[1];
    assign HEX2     = r_hex[2];
    assign HEX3     = r_hex[3];
    assign HEX4     = r_hex[4];
    assign HEX5     = r_hex[5];

endmodule
